// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receive front end: line sync, clock glitch filter, 11-bit frame
// deserialiser and E0/F0 prefix folding into one key event per scan code.
module ps2_scancode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       valid,
    output logic       make,
    output logic       extended,
    output logic [7:0] code,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_clk_q, fall_q;
    logic [FW-1:0] filt_cnt_q;
    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q, rx_byte_q;
    logic          par_q, byte_done_q, err_q;
    logic [TW-1:0] tmo_q;
    logic          ext_pend_q, brk_pend_q;
    logic          valid_q, make_q, ext_q;
    logic [7:0]    code_q;
    logic          frame_ok_d;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2_DAT;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_s2_q == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_q <= clk_s2_q;
                filt_cnt_q <= '0;
                fall_q     <= ~clk_s2_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    assign frame_ok_d = dat_s2_q & (^{shift_q, par_q});

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_done_q <= 1'b0;
            rx_byte_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            err_q       <= 1'b0;
            if (fall_q) begin
                tmo_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (frame_ok_d) begin
                            byte_done_q <= 1'b1;
                            rx_byte_q   <= shift_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                // A fall in the same cycle takes the other branch, so it always wins.
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q <= IDLE;
                    err_q   <= 1'b1;
                    tmo_q   <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            make_q     <= 1'b0;
            ext_q      <= 1'b0;
            code_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            if (err_q) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (byte_done_q) begin
                case (rx_byte_q)
                    8'hE0: ext_pend_q <= 1'b1;
                    8'hF0: brk_pend_q <= 1'b1;
                    default: begin
                        code_q     <= rx_byte_q;
                        make_q     <= ~brk_pend_q;
                        ext_q      <= ext_pend_q;
                        valid_q    <= 1'b1;
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign valid     = valid_q;
    assign make      = make_q;
    assign extended  = ext_q;
    assign code      = code_q;
    assign frame_err = err_q;
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: bit-banged PS/2 frames with
// hand-computed expected key events and error pulses.
module tb_ps2_scancode_receiver;
    localparam int FL  = 8;
    localparam int TMO = 2000;

    logic       clk_50 = 1'b0;
    logic       rst = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic       valid, make, extended, frame_err;
    logic [7:0] code;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int n_valid = 0, n_err = 0, n_fall = 0, last_fall = 0, lat = -1;
    logic [7:0] last_code = '0;
    logic last_make = 1'b0, last_ext = 1'b0;
    int n_both = 0;
    int v0, e0, f0;

    ps2_scancode_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_50(clk_50), .rst(rst), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .valid(valid), .make(make), .extended(extended), .code(code),
        .frame_err(frame_err)
    );

    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc_cnt++;

    always @(negedge clk_50) begin
        if (dut.fall_q) begin
            n_fall++;
            last_fall = cyc_cnt;
        end
        if (valid) begin
            n_valid++;
            last_code = code;
            last_make = make;
            last_ext  = extended;
            lat       = cyc_cnt - last_fall;
        end
        if (frame_err) n_err++;
        if (valid && frame_err) n_both++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic send_bit(input logic b);
        PS2_DAT = b;
        cyc(10);
        PS2_CLK = 1'b0;
        cyc(20);
        PS2_CLK = 1'b1;
        cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ par_flip);
        send_bit(stop);
        PS2_DAT = 1'b1;
        cyc(20);
    endtask

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
        f0 = n_fall;
    endtask

    initial begin
        cyc(4);
        @(negedge clk_50);
        chk("rst_valid", valid, 0);
        chk("rst_make", make, 0);
        chk("rst_ext", extended, 0);
        chk("rst_code", code, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 1'b0;
        cyc(20);

        // plain make 1C with latency check
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("1c_nvalid", n_valid - v0, 1);
        chk("1c_code", last_code, 8'h1C);
        chk("1c_make", last_make, 1);
        chk("1c_ext", last_ext, 0);
        chk("1c_nerr", n_err - e0, 0);
        chk("1c_latency", lat, 2);

        // extended press then release
        snap();
        send_frame(8'hE0, 1'b0, 1'b1);
        chk("e0_nvalid", n_valid - v0, 0);
        send_frame(8'h75, 1'b0, 1'b1);
        chk("e075_nvalid", n_valid - v0, 1);
        chk("e075_code", last_code, 8'h75);
        chk("e075_make", last_make, 1);
        chk("e075_ext", last_ext, 1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("e0f0_nvalid", n_valid - v0, 1);
        send_frame(8'h75, 1'b0, 1'b1);
        chk("brk_nvalid", n_valid - v0, 2);
        chk("brk_code", last_code, 8'h75);
        chk("brk_make", last_make, 0);
        chk("brk_ext", last_ext, 1);
        chk("ext_nerr", n_err - e0, 0);

        // parity error then good frame
        snap();
        send_frame(8'h75, 1'b1, 1'b1);
        chk("par_nerr", n_err - e0, 1);
        chk("par_nvalid", n_valid - v0, 0);
        send_frame(8'h72, 1'b0, 1'b1);
        chk("72_nvalid", n_valid - v0, 1);
        chk("72_code", last_code, 8'h72);
        chk("72_make", last_make, 1);
        chk("72_ext", last_ext, 0);

        // break prefix discarded by a bad-stop frame
        snap();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h11, 1'b0, 1'b0);
        chk("stop_nerr", n_err - e0, 1);
        send_frame(8'h6B, 1'b0, 1'b1);
        chk("6b_nvalid", n_valid - v0, 1);
        chk("6b_code", last_code, 8'h6B);
        chk("6b_make", last_make, 1);

        // timeout after start + 3 data bits
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        PS2_DAT = 1'b1;
        cyc(TMO + 10);
        chk("tmo_nerr", n_err - e0, 1);
        chk("tmo_nvalid", n_valid - v0, 0);
        send_frame(8'h74, 1'b0, 1'b1);
        chk("74_nvalid", n_valid - v0, 1);
        chk("74_code", last_code, 8'h74);
        chk("74_nerr", n_err - e0, 1);

        // short clock glitch must not register a fall
        snap();
        PS2_DAT = 1'b0;
        cyc(5);
        PS2_CLK = 1'b0;
        cyc(FL - 2);
        PS2_CLK = 1'b1;
        cyc(20);
        PS2_DAT = 1'b1;
        cyc(10);
        chk("glitch_nfall", n_fall - f0, 0);

        // reset in the middle of a frame
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        cyc(2);
        @(negedge clk_50);
        chk("mrst_valid", valid, 0);
        chk("mrst_make", make, 0);
        chk("mrst_ext", extended, 0);
        chk("mrst_code", code, 0);
        chk("mrst_ferr", frame_err, 0);
        rst = 1'b0;
        cyc(20);
        chk("mrst_nvalid", n_valid - v0, 0);
        chk("mrst_nerr", n_err - e0, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("post_nvalid", n_valid - v0, 1);
        chk("post_code", last_code, 8'h1C);
        chk("post_make", last_make, 1);
        chk("post_ext", last_ext, 0);
        chk("post_nerr", n_err - e0, 0);

        chk("valid_and_ferr", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
